// File: rtl/cpu_oci_trace_capture_pkg.sv
// Shared types and helpers for the OCI trace capture block.
package cpu_oci_trace_pkg;

  // dct_count value that marks a completed trace frame
  localparam int FLUSH_CNT_DEFAULT = 3;

  // Behaviour when a frame arrives and the FIFO is full
  typedef enum logic {
    STOP = 1'b0,  // drop the new frame
    WRAP = 1'b1   // overwrite the oldest stored frame
  } trace_mode_e;

  // Width of one stored entry: {count, payload}
  function automatic int entry_w(input int cnt_w, input int data_w);
    return cnt_w + data_w;
  endfunction

endpackage

// File: rtl/cpu_oci_trace_capture_if.sv
// Valid/ready drain port used to unload captured trace entries.
interface cpu_oci_trace_capture_if #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4
);
  import cpu_oci_trace_pkg::*;

  localparam int ENTRY_W = entry_w(CNT_W, DATA_W);

  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  // The capture block drives the data, the consumer drives ready
  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/cpu_oci_trace_capture_fifo.sv
// Show-ahead circular buffer with an explicit level counter and an
// overwrite-when-full option (oldest entry is discarded).
module cpu_oci_trace_fifo #(
  parameter int ENTRY_W = 34,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               overwrite,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [ADDR_W:0]    level,
  output logic               full,
  output logic               empty
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W + 1)'(1);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0]  rd_ptr_r;
  logic [ADDR_W:0]    level_r;

  logic pop_s;
  logic store_s;
  logic push_over_s;

  assign empty = (level_r == '0);
  assign full  = (level_r == LEVEL_FULL);
  assign level = level_r;

  // Decide whether the write lands, and whether it displaces the oldest entry
  always_comb begin
    pop_s       = rd_en & ~empty;
    store_s     = wr_en & (~full | pop_s | overwrite) & ~clear;
    push_over_s = wr_en & full & ~pop_s & overwrite;
  end

  // Storage array; contents are don't-care after reset so it carries none
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and level bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s | push_over_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({store_s & ~push_over_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Show-ahead read; forced to zero while empty so stale data never leaks out
  always_comb begin
    if (empty) begin
      rd_data = '0;
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/cpu_oci_trace_capture.sv
// Captures completed or flushed debug-trace frames into a FIFO, freezes at
// end of test and offers the stored frames on a valid/ready drain port.
module cpu_oci_trace_capture
  import cpu_oci_trace_pkg::*;
#(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int FLUSH_CNT = FLUSH_CNT_DEFAULT,
  parameter int ADDR_W    = 4,
  parameter int OVF_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]          dct_count,
  input  logic                      test_ending,
  input  logic                      test_has_ended,
  input  logic                      mode_wrap,
  input  logic                      clear,
  cpu_oci_trace_capture_if.master   rd_if,
  output logic [ADDR_W:0]           level,
  output logic [OVF_W-1:0]          overflow_cnt,
  output logic                      frozen,
  output logic                      drained
);
  localparam int ENTRY_W = entry_w(CNT_W, DATA_W);
  localparam logic [CNT_W-1:0] FLUSH_VAL = CNT_W'(FLUSH_CNT);
  localparam logic [OVF_W-1:0] OVF_ONE   = OVF_W'(1);

  logic [CNT_W-1:0]   prev_cnt_r;
  logic               prev_end_r;
  logic               frozen_r;
  logic               drained_r;
  logic [OVF_W-1:0]   ovf_r;

  trace_mode_e        mode_s;
  logic               cap_s;
  logic               flush_s;
  logic               wr_s;
  logic               pop_s;
  logic               ovf_s;
  logic               full_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] rd_data_s;

  assign mode_s = trace_mode_e'(mode_wrap);

  // Event detection: rising frame match, or a flush of a partial frame when
  // test_ending first rises (a partial count excludes the frame value, so the
  // two can never both fire)
  always_comb begin
    cap_s   = (dct_count == FLUSH_VAL) && (prev_cnt_r != FLUSH_VAL);
    flush_s = test_ending && !prev_end_r &&
              (dct_count != '0) && (dct_count != FLUSH_VAL);
    wr_s    = (cap_s | flush_s) & ~frozen_r;
    pop_s   = ~empty_s & rd_if.rd_ready;
    ovf_s   = wr_s & full_s & ~pop_s;
  end

  cpu_oci_trace_fifo #(
    .ENTRY_W (ENTRY_W),
    .ADDR_W  (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .wr_en     (wr_s),
    .wr_data   ({dct_count, dct_buffer}),
    .overwrite (mode_s == WRAP),
    .rd_en     (rd_if.rd_ready),
    .rd_data   (rd_data_s),
    .level     (level),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign rd_if.rd_valid = ~empty_s;
  assign rd_if.rd_data  = rd_data_s;
  assign overflow_cnt   = ovf_r;
  assign frozen         = frozen_r;
  assign drained        = drained_r;

  // Edge-detect history; keeps tracking even through a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_cnt_r <= '0;
      prev_end_r <= 1'b0;
    end else begin
      prev_cnt_r <= dct_count;
      prev_end_r <= test_ending;
    end
  end

  // Sticky freeze plus the registered drained flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frozen_r  <= 1'b0;
      drained_r <= 1'b0;
    end else if (clear) begin
      frozen_r  <= 1'b0;
      drained_r <= 1'b0;
    end else begin
      frozen_r  <= frozen_r | test_has_ended;
      drained_r <= frozen_r & empty_s;
    end
  end

  // Saturating count of dropped or overwritten frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r <= '0;
    end else if (clear) begin
      ovf_r <= '0;
    end else if (ovf_s && (ovf_r != '1)) begin
      ovf_r <= ovf_r + OVF_ONE;
    end else begin
      ovf_r <= ovf_r;
    end
  end

endmodule

// File: tb/tb_cpu_oci_trace_capture.sv
// Directed self-checking bench for cpu_oci_trace_capture.
module tb_cpu_oci_trace_capture;

  logic        clk;
  logic        reset_n;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic        mode_wrap;
  logic        clear;
  logic [4:0]  level;
  logic [7:0]  overflow_cnt;
  logic        frozen;
  logic        drained;

  int total;
  int bad;

  cpu_oci_trace_capture_if #(.DATA_W(30), .CNT_W(4)) drain_if ();

  cpu_oci_trace_capture #(
    .DATA_W(30), .CNT_W(4), .FLUSH_CNT(3), .ADDR_W(4), .OVF_W(8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .mode_wrap      (mode_wrap),
    .clear          (clear),
    .rd_if          (drain_if),
    .level          (level),
    .overflow_cnt   (overflow_cnt),
    .frozen         (frozen),
    .drained        (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: count reaches 3 for a single cycle, then drops back to 0
  task automatic frame(input logic [29:0] p);
    dct_buffer = p;
    dct_count  = 4'd3;
    tick();
    dct_count  = 4'd0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Pop n entries, expecting payloads first, first+1, ... with count 3
  task automatic drain_expect(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      check_eq("drain_valid", 64'(drain_if.rd_valid), 64'd1);
      check_eq("drain_data", 64'(drain_if.rd_data), 64'({4'd3, 30'(first + k)}));
      drain_if.rd_ready = 1'b1;
      tick();
      drain_if.rd_ready = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(drain_if.rd_valid), 64'd0);
    check_eq({tag, "_data"},  64'(drain_if.rd_data),  64'd0);
    check_eq({tag, "_level"}, 64'(level),             64'd0);
    check_eq({tag, "_ovf"},   64'(overflow_cnt),      64'd0);
    check_eq({tag, "_frozen"},64'(frozen),            64'd0);
    check_eq({tag, "_drained"},64'(drained),          64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    dct_buffer = 30'd0;
    dct_count = 4'd0;
    test_ending = 1'b0;
    test_has_ended = 1'b0;
    mode_wrap = 1'b0;
    clear = 1'b0;
    drain_if.rd_ready = 1'b0;

    // Reset, then idle
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    check_all_zero("idle");

    // Counting 1,2,3 with 3 held: exactly one entry
    dct_buffer = 30'h0ABCDEF3;
    dct_count = 4'd1; tick();
    dct_count = 4'd2; tick();
    check_eq("pre_cap_valid", 64'(drain_if.rd_valid), 64'd0);
    dct_count = 4'd3; tick();
    check_eq("cap_valid", 64'(drain_if.rd_valid), 64'd1);
    check_eq("cap_level", 64'(level), 64'd1);
    check_eq("cap_data", 64'(drain_if.rd_data), 64'({4'd3, 30'h0ABCDEF3}));
    repeat (3) tick();
    check_eq("held_level", 64'(level), 64'd1);
    dct_count = 4'd0;
    drain_if.rd_ready = 1'b1; tick();
    drain_if.rd_ready = 1'b0;
    check_eq("cap_drained_level", 64'(level), 64'd0);

    // Stop-on-full: 20 frames, keep the first 16
    mode_wrap = 1'b0;
    for (int i = 1; i <= 20; i++) frame(30'(i));
    check_eq("stop_level", 64'(level), 64'd16);
    check_eq("stop_ovf", 64'(overflow_cnt), 64'd4);
    drain_expect(1, 16);
    check_eq("stop_empty", 64'(drain_if.rd_valid), 64'd0);
    do_clear();
    check_eq("clear_ovf", 64'(overflow_cnt), 64'd0);

    // Wrap mode: 20 frames, keep the last 16
    mode_wrap = 1'b1;
    for (int i = 1; i <= 20; i++) frame(30'(i));
    check_eq("wrap_level", 64'(level), 64'd16);
    check_eq("wrap_ovf", 64'(overflow_cnt), 64'd4);
    drain_expect(5, 16);
    check_eq("wrap_empty_level", 64'(level), 64'd0);
    do_clear();
    mode_wrap = 1'b0;

    // Flush of a partial frame, freeze, then a late frame is ignored
    dct_buffer = 30'h123;
    dct_count = 4'd2; tick();
    test_ending = 1'b1; tick();
    check_eq("flush_level", 64'(level), 64'd1);
    check_eq("flush_data", 64'(drain_if.rd_data), 64'({4'd2, 30'h123}));
    dct_buffer = 30'h456;
    dct_count = 4'd3;
    test_has_ended = 1'b1; tick();
    check_eq("freeze_edge_level", 64'(level), 64'd2);
    check_eq("frozen_set", 64'(frozen), 64'd1);
    dct_count = 4'd0; tick();
    dct_buffer = 30'h789;
    dct_count = 4'd3; tick();
    dct_count = 4'd0; tick();
    check_eq("frozen_ignore_level", 64'(level), 64'd2);
    check_eq("flush_drain0", 64'(drain_if.rd_data), 64'({4'd2, 30'h123}));
    drain_if.rd_ready = 1'b1; tick();
    check_eq("flush_drain1", 64'(drain_if.rd_data), 64'({4'd3, 30'h456}));
    tick();
    drain_if.rd_ready = 1'b0;
    tick(); tick();
    check_eq("drained_set", 64'(drained), 64'd1);
    check_eq("drained_frozen", 64'(frozen), 64'd1);
    test_has_ended = 1'b0;
    test_ending = 1'b0;
    do_clear();
    check_eq("unfreeze", 64'(frozen), 64'd0);
    check_eq("undrain", 64'(drained), 64'd0);

    // Full in stop mode with a simultaneous pop and frame
    for (int i = 0; i < 16; i++) frame(30'(32'h100 + i));
    check_eq("full_level", 64'(level), 64'd16);
    dct_buffer = 30'h200;
    dct_count = 4'd3;
    drain_if.rd_ready = 1'b1; tick();
    drain_if.rd_ready = 1'b0;
    dct_count = 4'd0;
    check_eq("wrpop_level", 64'(level), 64'd16);
    check_eq("wrpop_ovf", 64'(overflow_cnt), 64'd0);
    check_eq("wrpop_data", 64'(drain_if.rd_data), 64'({4'd3, 30'h101}));
    tick();

    // Overflow counter saturates
    for (int i = 0; i < 260; i++) frame(30'h300);
    check_eq("sat_ovf", 64'(overflow_cnt), 64'd255);
    check_eq("sat_level", 64'(level), 64'd16);

    // Reset in the middle of a drain, between clock edges
    drain_if.rd_ready = 1'b1; tick();
    check_eq("middrain_data", 64'(drain_if.rd_data), 64'({4'd3, 30'h102}));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    drain_if.rd_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
